regfile_write_arbiter: RTL and testbench

//  Shares the single register-file write port between the pipeline writeback

---
 rtl/regfile_write_arbiter_if.sv | 25 ++
 rtl/regfile_write_arbiter.sv | 115 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - writeback, UART-config and register-file port bundle for the write arbiter
interface regfile_write_arbiter_if;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [4:0]  cfg_waddr;
    logic [31:0] cfg_wdata;
    logic        stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy;

    modport master (
        output wb_we, wb_waddr, wb_wdata, cfg_valid, cfg_waddr, cfg_wdata,
        input  cfg_ready, stall, rf_we, rf_waddr, rf_wdata, busy
    );

    modport slave (
        input  wb_we, wb_waddr, wb_wdata, cfg_valid, cfg_waddr, cfg_wdata,
        output cfg_ready, stall, rf_we, rf_waddr, rf_wdata, busy
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - register-file write port arbiter, writeback over buffered UART writes (RF_ARB_PERF_EN adds stall counter)
module regfile_write_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    regfile_write_arbiter_if.slave       bus
`ifdef RF_ARB_PERF_EN
    ,
    output logic [15:0]                  perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]  buf_addr_q;
    logic [31:0] buf_data_q;
    logic        buf_load;

    logic        drive_buf;
    logic        mux_we;
    logic [4:0]  mux_addr;
    logic [31:0] mux_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (buf_load) begin
                buf_addr_q <= bus.cfg_waddr;
                buf_data_q <= bus.cfg_wdata;
            end
        end
    end

    // A WB write to the buffered address supersedes the older UART value.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        buf_load = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.cfg_valid) begin
                    state_d  = PEND;
                    buf_load = 1'b1;
                end
            end
            PEND: begin
                if (!bus.wb_we || (bus.wb_waddr == buf_addr_q)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(MAX_WAIT - 1))
                        state_d = FORCE;
                end
            end
            FORCE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        drive_buf = (state_q == FORCE) || ((state_q == PEND) && !bus.wb_we);
        mux_we    = 1'b0;
        mux_addr  = '0;
        mux_data  = '0;
        if (drive_buf) begin
            mux_we   = 1'b1;
            mux_addr = buf_addr_q;
            mux_data = buf_data_q;
        end else if (bus.wb_we) begin
            mux_we   = 1'b1;
            mux_addr = bus.wb_waddr;
            mux_data = bus.wb_wdata;
        end
    end

    // x0 writes are swallowed here so both sources complete normally.
    assign bus.rf_we     = mux_we && (mux_addr != 5'd0) && !rst;
    assign bus.rf_waddr  = mux_addr;
    assign bus.rf_wdata  = mux_data;
    assign bus.stall     = (state_q == FORCE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.cfg_ready = (state_q == IDLE);

`ifdef RF_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perf_stall_cnt <= '0;
        else if ((state_q == FORCE) && (perf_stall_cnt != 16'hFFFF))
            perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
    localparam int MAX_WAIT = 4;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    regfile_write_arbiter_if bus ();
`ifdef RF_ARB_PERF_EN
    logic [15:0] perf_stall_cnt;
`endif

    regfile_write_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef RF_ARB_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an optional pending UART write plus how many cycles WB has held it off.
    logic        m_valid;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          m_blocked;
    logic [31:0] exp_rf [32] = '{default: 32'h0};
    logic [31:0] dut_rf [32] = '{default: 32'h0};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid   <= 1'b0;
            m_blocked <= 0;
        end else if (m_valid) begin
            if (m_blocked >= MAX_WAIT) begin
                if (m_addr != 0) exp_rf[m_addr] <= m_data;
                m_valid   <= 1'b0;
                m_blocked <= 0;
            end else if (bus.wb_we) begin
                if (bus.wb_waddr != 0) exp_rf[bus.wb_waddr] <= bus.wb_wdata;
                if (bus.wb_waddr == m_addr) begin
                    m_valid   <= 1'b0;
                    m_blocked <= 0;
                end else begin
                    m_blocked <= m_blocked + 1;
                end
            end else begin
                if (m_addr != 0) exp_rf[m_addr] <= m_data;
                m_valid   <= 1'b0;
                m_blocked <= 0;
            end
        end else begin
            if (bus.wb_we && bus.wb_waddr != 0) exp_rf[bus.wb_waddr] <= bus.wb_wdata;
            if (bus.cfg_valid) begin
                m_valid   <= 1'b1;
                m_addr    <= bus.cfg_waddr;
                m_data    <= bus.cfg_wdata;
                m_blocked <= 0;
            end
        end
    end

    always @(negedge clk) begin
        logic        e_force;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        e_force = m_valid && (m_blocked >= MAX_WAIT);
        e_we    = 1'b0;
        e_addr  = 5'd0;
        e_data  = 32'd0;
        if (e_force || (m_valid && !bus.wb_we)) begin
            e_we = 1'b1; e_addr = m_addr; e_data = m_data;
        end else if (bus.wb_we) begin
            e_we = 1'b1; e_addr = bus.wb_waddr; e_data = bus.wb_wdata;
        end
        if (rst || e_addr == 5'd0) e_we = 1'b0;
        check("cfg_ready", 32'(bus.cfg_ready), 32'(rst || !m_valid));
        check("busy",      32'(bus.busy),      32'(!rst && m_valid));
        check("stall",     32'(bus.stall),     32'(!rst && e_force));
        check("rf_we",     32'(bus.rf_we),     32'(e_we));
        if (e_we) begin
            check("rf_waddr", 32'(bus.rf_waddr), 32'(e_addr));
            check("rf_wdata", bus.rf_wdata, e_data);
        end
        if (bus.rf_we) dut_rf[bus.rf_waddr] <= bus.rf_wdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] a, input logic [31:0] d);
        bus.wb_we = we; bus.wb_waddr = a; bus.wb_wdata = d;
    endtask

    task automatic set_cfg(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.cfg_valid = v; bus.cfg_waddr = a; bus.cfg_wdata = d;
    endtask

`ifdef RF_ARB_PERF_EN
    task automatic forced_drain(input logic [4:0] ca, input logic [4:0] wa);
        set_wb(1'b0, 5'd0, 32'd0);
        set_cfg(1'b1, ca, 32'h0000_1000 + 32'(ca));
        step();
        set_cfg(1'b0, 5'd0, 32'd0);
        set_wb(1'b1, wa, 32'h0000_2000 + 32'(wa));
        repeat (MAX_WAIT + 2) step();
        set_wb(1'b0, 5'd0, 32'd0);
        step();
    endtask
`endif

    initial begin
        rst = 1'b1;
        set_wb(1'b0, 5'd0, 32'd0);
        set_cfg(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check("reset cfg_ready", 32'(bus.cfg_ready), 32'd1);
        check("reset busy", 32'(bus.busy), 32'd0);
        step();
        rst = 1'b0;

        // Idle pass-through
        set_wb(1'b1, 5'd5, 32'hDEADBEEF);
        @(negedge clk);
        check("t1 rf_we", 32'(bus.rf_we), 32'd1);
        check("t1 rf_waddr", 32'(bus.rf_waddr), 32'd5);
        check("t1 rf_wdata", bus.rf_wdata, 32'hDEADBEEF);
        check("t1 stall", 32'(bus.stall), 32'd0);
        step();

        // UART drain on an idle WB cycle
        set_wb(1'b0, 5'd0, 32'd0);
        set_cfg(1'b1, 5'd7, 32'h12345678);
        @(negedge clk);
        check("t2 ready before", 32'(bus.cfg_ready), 32'd1);
        step();
        set_cfg(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check("t2 ready low", 32'(bus.cfg_ready), 32'd0);
        check("t2 rf_waddr", 32'(bus.rf_waddr), 32'd7);
        check("t2 rf_wdata", bus.rf_wdata, 32'h12345678);
        step();
        @(negedge clk);
        check("t2 ready back", 32'(bus.cfg_ready), 32'd1);
        step();

        // Forced drain after MAX_WAIT blocked cycles
        set_cfg(1'b1, 5'd3, 32'hA5A5A5A5);
        step();
        set_cfg(1'b0, 5'd0, 32'd0);
        set_wb(1'b1, 5'd9, 32'h0000_0099);
        for (int k = 1; k <= MAX_WAIT + 2; k++) begin
            @(negedge clk);
            check("t3 stall", 32'(bus.stall), 32'(k == MAX_WAIT + 1));
            if (k == MAX_WAIT + 1)
                check("t3 forced addr", 32'(bus.rf_waddr), 32'd3);
            if (k == MAX_WAIT + 2)
                check("t3 wb rewrite addr", 32'(bus.rf_waddr), 32'd9);
            step();
        end
        set_wb(1'b0, 5'd0, 32'd0);
        step();
        check("t3 x3", dut_rf[3], 32'hA5A5A5A5);
        check("t3 model x3", exp_rf[3], 32'hA5A5A5A5);

        // Coherence: newer WB write to the buffered address wins
        set_cfg(1'b1, 5'd4, 32'h1);
        step();
        set_cfg(1'b0, 5'd0, 32'd0);
        set_wb(1'b1, 5'd4, 32'h2);
        @(negedge clk);
        check("t4 busy during", 32'(bus.busy), 32'd1);
        step();
        set_wb(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check("t4 busy after", 32'(bus.busy), 32'd0);
        check("t4 no drain", 32'(bus.rf_we), 32'd0);
        step();
        step();
        check("t4 x4", dut_rf[4], 32'h2);
        check("t4 model x4", exp_rf[4], 32'h2);

        // x0 write handshakes but never reaches the register file
        set_cfg(1'b1, 5'd0, 32'hFFFFFFFF);
        @(negedge clk);
        check("t5 x0 ready", 32'(bus.cfg_ready), 32'd1);
        step();
        set_cfg(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check("t5 x0 busy", 32'(bus.busy), 32'd1);
        check("t5 x0 rf_we", 32'(bus.rf_we), 32'd0);
        step();
        @(negedge clk);
        check("t5 x0 ready after", 32'(bus.cfg_ready), 32'd1);
        step();

        // Reset while pending drops the buffered write
        set_cfg(1'b1, 5'd8, 32'h55);
        step();
        set_cfg(1'b0, 5'd0, 32'd0);
        set_wb(1'b1, 5'd10, 32'hAA);
        rst = 1'b1;
        @(negedge clk);
        check("t5 rst busy", 32'(bus.busy), 32'd0);
        check("t5 rst ready", 32'(bus.cfg_ready), 32'd1);
        check("t5 rst rf_we", 32'(bus.rf_we), 32'd0);
        step();
        rst = 1'b0;
        set_wb(1'b0, 5'd0, 32'd0);
        repeat (3) step();
        check("t5 x8 unwritten", dut_rf[8], 32'h0);
        check("t5 x10 unwritten", dut_rf[10], 32'h0);

`ifdef RF_ARB_PERF_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6 perf cleared", 32'(perf_stall_cnt), 32'd0);
        forced_drain(5'd11, 5'd12);
        forced_drain(5'd13, 5'd14);
        forced_drain(5'd15, 5'd16);
        check("t6 perf count", 32'(perf_stall_cnt), 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
